// File: rtl/accum_adder_tree.sv
// Pipelined signed adder tree feeding a multi-beat accumulator; one result pulse per last beat.
// Optional macro ACCUM_ADDER_TREE_SAT_EN selects saturating accumulation with a sticky overflow flag.
module accum_adder_tree #(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_INPUTS  = 27,
   parameter int PIPE_STRIDE = 2,
   parameter int ACC_WIDTH   = 32
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [DATA_WIDTH*NUM_INPUTS-1:0]     i_data,
   input  logic                                 i_valid,
   input  logic                                 i_last,
   output logic signed [ACC_WIDTH-1:0]          o_data,
   output logic                                 o_valid,
   output logic                                 o_overflow
);

   localparam int L   = $clog2(NUM_INPUTS);
   localparam int T   = (L + PIPE_STRIDE - 1) / PIPE_STRIDE - 1;
   localparam int TA  = (T > 0) ? T : 1;
   localparam int SW  = DATA_WIDTH + L;
   localparam int AW1 = ACC_WIDTH + 1;

   // Nodes are held at the final tree width; layer k sums always fit in DATA_WIDTH+k+1 bits.
   typedef logic signed [SW-1:0] node_t;

   node_t         pin [0:TA-1][0:NUM_INPUTS];
   node_t         pq  [0:TA-1][0:NUM_INPUTS];
   node_t         tree_sum;
   logic [TA-1:0] sv;
   logic [TA-1:0] sl;
   logic [TA-1:0] en;
   logic          t_valid;
   logic          t_last;

   always_comb begin : tree
      node_t cur [0:NUM_INPUTS];
      node_t nxt [0:NUM_INPUTS];
      int    n;
      int    r;
      for (int j = 0; j <= NUM_INPUTS; j++) begin
         cur[j] = '0;
         nxt[j] = '0;
      end
      for (int s = 0; s < TA; s++) begin
         for (int j = 0; j <= NUM_INPUTS; j++) begin
            pin[s][j] = '0;
         end
      end
      for (int j = 0; j < NUM_INPUTS; j++) begin
         cur[j] = {{L{i_data[(j+1)*DATA_WIDTH-1]}}, i_data[j*DATA_WIDTH +: DATA_WIDTH]};
      end
      n = NUM_INPUTS;
      r = 0;
      for (int k = 0; k < L; k++) begin
         for (int j = 0; j <= NUM_INPUTS; j++) begin
            nxt[j] = '0;
         end
         // Pairwise sums; an odd leftover operand passes straight through.
         for (int i = 0; i < (NUM_INPUTS + 1) / 2; i++) begin
            if (2 * i + 1 < n) begin
               nxt[i] = cur[2*i] + cur[2*i+1];
            end else if (2 * i < n) begin
               nxt[i] = cur[2*i];
            end
         end
         n = (n + 1) / 2;
         if (((k + 1) % PIPE_STRIDE) == 0 && k != L - 1) begin
            pin[r] = nxt;
            cur    = pq[r];
            r      = r + 1;
         end else begin
            cur = nxt;
         end
      end
      tree_sum = cur[0];
   end

   always_comb begin
      en    = '0;
      en[0] = i_valid;
      for (int s = 1; s < TA; s++) begin
         en[s] = sv[s-1];
      end
   end

   // Data registers carry no reset; they only ever load alongside a valid stage bit.
   always_ff @(posedge clk) begin
      for (int s = 0; s < T; s++) begin
         if (en[s]) begin
            pq[s] <= pin[s];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sv <= '0;
         sl <= '0;
      end else begin
         sv[0] <= i_valid;
         sl[0] <= i_valid & i_last;
         for (int s = 1; s < TA; s++) begin
            sv[s] <= sv[s-1];
            sl[s] <= sl[s-1];
         end
      end
   end

   // A beat is qualified by valid alone: i_last and i_data mean nothing while valid is low.
   assign t_valid = (T == 0) ? i_valid : sv[TA-1];
   assign t_last  = (T == 0) ? (i_valid & i_last) : sl[TA-1];

   logic signed [AW1-1:0]       tree_ext;
   logic signed [AW1-1:0]       addend;
   logic signed [AW1-1:0]       sum_ext;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] result;
   logic                        first;

   assign tree_ext = {{(AW1-SW){tree_sum[SW-1]}}, tree_sum};
   assign addend   = first ? '0 : {acc[ACC_WIDTH-1], acc};
   assign sum_ext  = tree_ext + addend;

`ifdef ACCUM_ADDER_TREE_SAT_EN
   logic clamp;
   logic ovf;
   logic ovf_now;

   always_comb begin
      clamp  = 1'b0;
      result = sum_ext[ACC_WIDTH-1:0];
      if (sum_ext[AW1-1] != sum_ext[AW1-2]) begin
         clamp  = 1'b1;
         result = sum_ext[AW1-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end

   assign ovf_now = (ovf & ~first) | clamp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf        <= 1'b0;
         o_overflow <= 1'b0;
      end else if (t_valid) begin
         ovf <= t_last ? 1'b0 : ovf_now;
         if (t_last) begin
            o_overflow <= ovf_now;
         end
      end
   end
`else
   assign result     = sum_ext[ACC_WIDTH-1:0];
   assign o_overflow = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         first   <= 1'b1;
         o_data  <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= t_valid & t_last;
         if (t_valid) begin
            acc   <= result;
            first <= t_last;
            if (t_last) begin
               o_data <= result;
            end
         end
      end
   end

endmodule

// File: tb/tb_accum_adder_tree.sv
// Directed bench for accum_adder_tree: default instance plus a 24-bit accumulator instance.
// Expectations for the 24-bit overflow case follow ACCUM_ADDER_TREE_SAT_EN.
module tb_accum_adder_tree;

   localparam int DW   = 16;
   localparam int NI   = 27;
   localparam int AW   = 32;
   localparam int AW24 = 24;
   localparam int BW   = DW * NI;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [BW-1:0]          i_data;
   logic                   i_valid;
   logic                   i_last;
   logic signed [AW-1:0]   o_data;
   logic                   o_valid;
   logic                   o_overflow;
   logic signed [AW24-1:0] o_data24;
   logic                   o_valid24;
   logic                   o_overflow24;

   int          checks = 0;
   int          errors = 0;
   logic [AW:0] exp_q[$];

   accum_adder_tree dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .i_last     (i_last),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_overflow (o_overflow)
   );

   accum_adder_tree #(.ACC_WIDTH(AW24)) dut24 (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .i_last     (i_last),
      .o_data     (o_data24),
      .o_valid    (o_valid24),
      .o_overflow (o_overflow24)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [BW-1:0] splat(input logic [DW-1:0] v);
      logic [BW-1:0] r;
      for (int j = 0; j < NI; j++) r[j*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [BW-1:0] op0(input logic [DW-1:0] v);
      logic [BW-1:0] r;
      r = '0;
      r[DW-1:0] = v;
      return r;
   endfunction

   function automatic logic [BW-1:0] rand_data();
      logic [BW-1:0] r;
      for (int j = 0; j < NI; j++) r[j*DW +: DW] = DW'($urandom_range(0, 65535));
      return r;
   endfunction

   // driver tasks
   task automatic beat(input logic [BW-1:0] d, input logic last);
      @(negedge clk);
      i_data  = d;
      i_valid = 1'b1;
      i_last  = last;
   endtask

   task automatic idle();
      @(negedge clk);
      i_valid = 1'b0;
      i_last  = 1'($urandom_range(0, 1));
      i_data  = rand_data();
   endtask

   task automatic push(input logic signed [AW-1:0] d, input logic ov);
      exp_q.push_back({ov, d});
   endtask

   // scoreboard
   always @(negedge clk) begin : monitor
      logic [AW:0] e;
      if (o_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_o_valid", {63'd0, o_valid}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("sb_o_data", o_data, $signed(e[AW-1:0]));
            check("sb_o_overflow", {63'd0, o_overflow}, {63'd0, e[AW]});
         end
      end
   end

   initial begin : stim
      int w;
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_data  = '0;
      repeat (2) @(negedge clk);
      check("reset_o_valid", {63'd0, o_valid}, 64'd0);
      check("reset_o_data", o_data, 64'd0);
      check("reset_o_overflow", {63'd0, o_overflow}, 64'd0);
      check("reset_o_data24", o_data24, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle();

      // single beat of +1, latency three cycles
      push(27, 1'b0);
      beat(splat(16'd1), 1'b1);
      idle();
      check("lat1_o_valid", {63'd0, o_valid}, 64'd0);
      idle();
      check("lat2_o_valid", {63'd0, o_valid}, 64'd0);
      idle();
      check("lat3_o_valid", {63'd0, o_valid}, 64'd1);
      repeat (3) idle();
      check("hold_o_data", o_data, 64'd27);
      check("hold_o_valid", {63'd0, o_valid}, 64'd0);

      // four beats of -1 with two-cycle gaps of junk data
      push(-108, 1'b0);
      for (int b = 1; b <= 4; b++) begin
         beat(splat(16'hFFFF), (b == 4));
         if (b < 4) begin
            idle();
            idle();
         end
      end
      repeat (6) idle();
      check("gap_o_data", o_data, -64'sd108);

      // back-to-back single-beat accumulations
      push(5, 1'b0);
      push(7, 1'b0);
      beat(op0(16'd5), 1'b1);
      beat(op0(16'd7), 1'b1);
      idle();
      idle();
      check("b2b_first_valid", {63'd0, o_valid}, 64'd1);
      check("b2b_first_data", o_data, 64'd5);
      idle();
      check("b2b_second_valid", {63'd0, o_valid}, 64'd1);
      check("b2b_second_data", o_data, 64'd7);
      idle();
      check("b2b_after_valid", {63'd0, o_valid}, 64'd0);
      repeat (3) idle();

      // ten beats of 32767: 8847090 overflows a 24-bit accumulator
      push(8847090, 1'b0);
      for (int b = 1; b <= 10; b++) beat(splat(16'd32767), (b == 10));
      w = 0;
      do begin
         idle();
         w++;
      end while (!o_valid24 && w < 8);
      check("acc24_o_valid", {63'd0, o_valid24}, 64'd1);
      check("acc24_latency", w, 64'd3);
`ifdef ACCUM_ADDER_TREE_SAT_EN
      check("acc24_o_data", o_data24, 64'd8388607);
      check("acc24_o_overflow", {63'd0, o_overflow24}, 64'd1);
`else
      check("acc24_o_data", o_data24, -64'sd7930126);
      check("acc24_o_overflow", {63'd0, o_overflow24}, 64'd0);
`endif
      repeat (4) idle();

      // reset mid-accumulation, then a fresh beat of +2
      beat(splat(16'd3), 1'b0);
      beat(splat(16'd3), 1'b0);
      @(negedge clk);
      i_valid = 1'b0;
      i_last  = 1'b0;
      rst_n   = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_o_valid", {63'd0, o_valid}, 64'd0);
      check("midrst_o_data", o_data, 64'd0);
      check("midrst_o_data24", o_data24, 64'd0);
      check("midrst_o_overflow24", {63'd0, o_overflow24}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      push(54, 1'b0);
      beat(splat(16'd2), 1'b1);
      repeat (6) idle();
      check("post_rst_o_data", o_data, 64'd54);

      w = 0;
      while (exp_q.size() != 0 && w < 20) begin
         idle();
         w++;
      end
      check("queue_drained", exp_q.size(), 64'd0);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
